arith_add_sub_sequencer: RTL
============================

# arith_add_sub_sequencer

Multi-cycle controller that performs WIDTH×WORDS-bit add/subtract by sequencing one WIDTH-bit carry-chained slice adder over WORDS cycles, least-significant slice first. It sits between an issuing stage and its consumer in the Arith group and trades latency for adder area on wide operands. Both sides use valid/ready handshakes. It reports the standard Alu status flags for the full-width result.

## Interface
- WIDTH, 8, slice width in bits (≥2)
- WORDS, 4, slice count (≥1); full width N = WIDTH*WORDS
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts request
- req_data1  in  N  minuend / addend
- req_data2  in  N  subtrahend / addend
- req_addsub  in  Arith_AddSub_T  ADD=0, SUB=1
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  N  data1 ± data2 mod 2^N
- rsp_status  out  Alu_Status_T  {overflow, carry, negative, zero}

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch data1, data2 (inverted if SUB) and op; slice index=0; carry=op (1 for SUB); go to RUN.
- RUN: each cycle add slice[idx] of both operands plus carry, write the sum into result slice idx, and register the carry out. When idx==WORDS-1, capture the carry into the MSB and the carry out of the MSB, then go to DONE. Otherwise idx+1.
- DONE: rsp_valid=1; result and status held stable. On rsp_ready go to IDLE.
- Status rules:
  - carry = carry out of bit N-1. For SUB, 1 means no borrow.
  - overflow = carry into bit N-1 XOR carry out of bit N-1.
  - negative = result[N-1].
  - zero = (result==0).
- Input operand changes after acceptance have no effect.
- Reset low: next edge forces IDLE, clears result, status and index, and drops any in-flight op. rsp_valid=0 and req_ready=0 while reset is low.

## Timing
- Request accepted at edge T. rsp_valid rises after edge T+WORDS.
- Without the macro: minimum initiation interval is WORDS+2 cycles (IDLE re-entry costs one cycle).
- rsp_valid stays high until the rsp_ready handshake. The response is never dropped or overwritten.
- WORDS=1: RUN lasts exactly one cycle.
- Slice index wraps only via reset/IDLE. It never exceeds WORDS-1.
- req_ready is combinational from state only, with no path from req_valid.

## Configuration
- ARITH_ADDSUB_SEQ_PIPE_EN defined:
  - In DONE, req_ready = rsp_ready.
  - A simultaneous response and request handshake goes directly to RUN with the new operands.
  - Initiation interval becomes WORDS+1.
- Undefined: req_ready=0 in DONE. A new request is accepted only in IDLE.

## Structure
- Arith_AddSub_T and Alu_Status_T (field order overflow, carry, negative, zero) are shared package typedefs. They are not redeclared locally.
- The FSM state encoding is a localparam enum inside the block.
- There is one natural sub-module, Arith_addSubtractCarry: a combinational WIDTH-bit adder with carry-in. Its outputs are the sum, the carry-out and the carry into the slice MSB. The controller instantiates it once.

## Test plan
All scenarios use WIDTH=4, WORDS=2 (N=8).
- ADD 0x7F+0x01, accepted at T → rsp at T+2: result 0x80, overflow=1, negative=1, carry=0, zero=0.
- SUB 0x00−0x01 → result 0xFF, carry=0, negative=1, overflow=0, zero=0.
- SUB 0x35−0x35 → result 0x00, zero=1, carry=1, overflow=0.
- ADD 0xFF+0x01 → result 0x00, carry=1, zero=1, overflow=0.
- Backpressure: hold rsp_ready=0 for 5 cycles with req_valid=1 → result and status stable, req_ready=0 throughout. The second request is accepted only after the handshake (same cycle with the macro, next cycle without).
- Assert reset during RUN → rsp_valid never rises for that op. req_ready=1 on the first cycle after release. A following ADD 0x12+0x34 returns 0x46.

Source files
------------

// File: rtl/arith_add_sub_sequencer_pkg.sv
// Shared Arith/Alu typedefs for the multi-cycle add/subtract sequencer.
//   Arith_AddSub_T : operation select (ADD=0, SUB=1)
//   Alu_Status_T   : {overflow, carry, negative, zero} for a full-width result
package arith_add_sub_sequencer_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } Arith_AddSub_T;

  typedef struct packed {
    logic overflow;
    logic carry;
    logic negative;
    logic zero;
  } Alu_Status_T;

endpackage : arith_add_sub_sequencer_pkg

// File: rtl/arith_add_sub_sequencer_add_sub_carry.sv
// Arith_addSubtractCarry: combinational WIDTH-bit slice adder with carry-in.
// Ports:
//   a_i, b_i  : slice operands (b_i already inverted by the caller for SUB)
//   cin_i     : carry into bit 0
//   sum_o     : a_i + b_i + cin_i (mod 2^WIDTH)
//   cout_o    : carry out of bit WIDTH-1
//   cmsb_o    : carry into bit WIDTH-1 (for signed-overflow detection)
module Arith_addSubtractCarry #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [WIDTH-1:0] low_sum;

  // Lower WIDTH-1 bits added with a spare top bit that captures the carry into the MSB.
  assign low_sum = {1'b0, a_i[WIDTH-2:0]} + {1'b0, b_i[WIDTH-2:0]} + WIDTH'(cin_i);
  assign cmsb_o  = low_sum[WIDTH-1];
  assign sum_o   = {a_i[WIDTH-1] ^ b_i[WIDTH-1] ^ cmsb_o, low_sum[WIDTH-2:0]};
  assign cout_o  = (a_i[WIDTH-1] & b_i[WIDTH-1]) |
                   (cmsb_o & (a_i[WIDTH-1] ^ b_i[WIDTH-1]));

endmodule : Arith_addSubtractCarry

// File: rtl/arith_add_sub_sequencer.sv
// arith_add_sub_sequencer: WIDTH*WORDS-bit add/subtract computed one WIDTH-bit
// slice per cycle (LSB slice first) through a single carry-chained slice adder.
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-low reset
//   req_valid/req_ready     : request handshake; req_data1 +/- req_data2 per req_addsub
//   rsp_valid/rsp_ready     : response handshake; rsp_result and rsp_status held in DONE
// Option: ARITH_ADDSUB_SEQ_PIPE_EN lets a new request be taken in the same cycle
// the response is consumed (DONE -> RUN directly).
module arith_add_sub_sequencer
  import arith_add_sub_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WORDS = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WIDTH*WORDS-1:0]   req_data1,
  input  logic [WIDTH*WORDS-1:0]   req_data2,
  input  Arith_AddSub_T            req_addsub,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH*WORDS-1:0]   rsp_result,
  output Alu_Status_T              rsp_status
);

  localparam int unsigned N     = WIDTH * WORDS;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       op1_q, op1_d;
  logic [N-1:0]       op2_q, op2_d;
  logic [N-1:0]       result_q, result_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  Alu_Status_T        status_q, status_d;

  logic [WIDTH-1:0]   slice_a, slice_b, slice_sum;
  logic               slice_cout, slice_cmsb;
  logic               ready_state;
  logic               accept;

  // Ready depends on state only (plus rsp_ready in the pipelined build), never on req_valid.
  always_comb begin
    ready_state = (state_q == IDLE);
`ifdef ARITH_ADDSUB_SEQ_PIPE_EN
    if (state_q == DONE) ready_state = rsp_ready;
`endif
  end

  assign req_ready  = reset & ready_state;
  assign rsp_valid  = reset & (state_q == DONE);
  assign accept     = req_valid & req_ready;
  assign rsp_result = result_q;
  assign rsp_status = status_q;

  // Operand slice selected by the current index.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int w = 0; w < int'(WORDS); w++) begin
      if (idx_q == IDX_W'(w)) begin
        slice_a = op1_q[w*WIDTH +: WIDTH];
        slice_b = op2_q[w*WIDTH +: WIDTH];
      end
    end
  end

  Arith_addSubtractCarry #(
    .WIDTH (WIDTH)
  ) u_slice_adder (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout),
    .cmsb_o (slice_cmsb)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    result_d = result_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    status_d = status_q;

    unique case (state_q)
      IDLE: ;
      RUN: begin
        for (int w = 0; w < int'(WORDS); w++) begin
          if (idx_q == IDX_W'(w)) result_d[w*WIDTH +: WIDTH] = slice_sum;
        end
        carry_d = slice_cout;
        if (idx_q == IDX_W'(WORDS - 1)) begin
          // Last slice holds the full-width MSB, so its carries give the status.
          status_d.overflow = slice_cmsb ^ slice_cout;
          status_d.carry    = slice_cout;
          status_d.negative = slice_sum[WIDTH-1];
          status_d.zero     = (result_d == '0);
          state_d           = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Subtraction is a + ~b + 1: invert data2 and seed the carry with 1.
    if (accept) begin
      op1_d   = req_data1;
      op2_d   = (req_addsub == SUB) ? ~req_data2 : req_data2;
      carry_d = (req_addsub == SUB);
      idx_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      op1_q    <= '0;
      op2_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      status_q <= status_d;
    end
  end

endmodule : arith_add_sub_sequencer
